io_channel_bank: RTL and testbench

IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

---
 rtl/io_channel_bank.sv | 95 +++++++++
 tb/tb_io_channel_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/io_channel_bank.sv
// io_channel_bank: per-channel input capture registers and output FIFOs, addressed by a core read/write port
module io_channel_bank #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 15,
  parameter int FIFO_DEPTH = 4,
  parameter logic [NUM_CH-1:0] CH_DIR = 8'hF0,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         IO_read_sel,
  input  logic                     IO_read_en,
  output logic [DATA_W-1:0]        IO_read_data,
  input  logic                     IO_write_en,
  input  logic [SEL_W-1:0]         IO_write_sel,
  input  logic [DATA_W-1:0]        IO_write_data,
  output logic                     stall,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  input  logic [NUM_CH-1:0]        in_strobe,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        irq_en,
  output logic                     irq,
  output logic [NUM_CH-1:0]        overrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [SEL_W:0] NCH = NUM_CH[SEL_W:0];
  localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];
  logic [NUM_CH-1:0] w_pend, w_block;
  logic [DATA_W-1:0] w_rd [NUM_CH];
  logic r_irq;
  assign stall = |w_block;
  assign IO_read_data = ({1'b0, IO_read_sel} < NCH) ? w_rd[IO_read_sel] : '0;
  assign irq = r_irq;
  // interrupt line follows enabled pending inputs one cycle later
  always_ff @(posedge clock) r_irq <= reset_n ? |(w_pend & irq_en) : 1'b0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (CH_DIR[i]) begin : g_out
      logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
      logic [DATA_W-1:0] r_shadow;
      logic [PW-1:0] r_wp, r_rp;
      logic [PW:0] r_cnt;
      logic w_hit, w_pop, w_push;
      assign w_hit = IO_write_en && IO_write_sel == SEL_W'(i);
      assign w_pop = (r_cnt != '0) && out_ready[i];
      assign w_push = w_hit && (r_cnt != FULL || w_pop);
      assign w_block[i] = w_hit && r_cnt == FULL && !w_pop;
      assign out_valid[i] = r_cnt != '0;
      assign out_data[i*DATA_W +: DATA_W] = r_mem[r_rp];
      assign w_rd[i] = r_shadow;
      assign w_pend[i] = 1'b0;
      assign overrun[i] = 1'b0;
      // FIFO storage, wrapping pointers, occupancy and shadow copy of the last accepted word
      always_ff @(posedge clock)
        if (!reset_n) begin
          for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
          r_shadow <= '0;
          r_wp <= '0;
          r_rp <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wp] <= IO_write_data;
            r_shadow <= IO_write_data;
            r_wp <= r_wp + PW'(1);
          end
          if (w_pop) r_rp <= r_rp + PW'(1);
          r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end else begin : g_in
      logic [DATA_W-1:0] r_data;
      logic r_pend, r_ovr;
      assign out_valid[i] = 1'b0;
      assign out_data[i*DATA_W +: DATA_W] = '0;
      assign w_block[i] = 1'b0;
      assign w_rd[i] = r_data;
      assign w_pend[i] = r_pend;
      assign overrun[i] = r_ovr;
      // capture on strobe; a strobe always beats a same-cycle read, and hitting a pending word is sticky overrun
      always_ff @(posedge clock)
        if (!reset_n) begin
          r_data <= '0;
          r_pend <= 1'b0;
          r_ovr <= 1'b0;
        end else begin
          if (in_strobe[i]) begin
            r_data <= in_data[i*DATA_W +: DATA_W];
            r_ovr <= r_ovr | r_pend;
          end
          r_pend <= in_strobe[i] | (r_pend & !(IO_read_en && IO_read_sel == SEL_W'(i)));
        end
    end
  end
endmodule

// File: tb/tb_io_channel_bank.sv
// tb_io_channel_bank: directed scoreboard bench for io_channel_bank
module tb_io_channel_bank;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 15;
  localparam int SEL_W = 3;
  logic clock = 0, reset_n = 0;
  logic [SEL_W-1:0] IO_read_sel = '0, IO_write_sel = '0;
  logic IO_read_en = 0, IO_write_en = 0, stall, irq;
  logic [DATA_W-1:0] IO_read_data, IO_write_data = '0;
  logic [NUM_CH-1:0] out_valid, out_ready = '0, in_strobe = '0, irq_en = '0, overrun;
  logic [NUM_CH*DATA_W-1:0] out_data, in_data = '0;
  logic [DATA_W-1:0] q [NUM_CH][$];
  int ncmp = 0, nfail = 0;

  io_channel_bank dut (
    .clock(clock), .reset_n(reset_n),
    .IO_read_sel(IO_read_sel), .IO_read_en(IO_read_en), .IO_read_data(IO_read_data),
    .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
    .stall(stall), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .in_strobe(in_strobe), .in_data(in_data), .irq_en(irq_en), .irq(irq), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] od(input int c);
    return out_data[c*DATA_W +: DATA_W];
  endfunction

  // scoreboard: every pop the device side takes must match the oldest word written to that channel
  always @(negedge clock)
    for (int c = 0; c < NUM_CH; c++)
      if (reset_n && out_valid[c] && out_ready[c]) begin
        if (q[c].size() == 0) chk($sformatf("pop_unexpected_ch%0d", c), 32'(od(c)), 32'hFFFF_FFFF);
        else chk($sformatf("pop_data_ch%0d", c), 32'(od(c)), 32'(q[c].pop_front()));
      end

  task automatic wr(input int ch, input logic [DATA_W-1:0] d);
    IO_write_en = 1;
    IO_write_sel = SEL_W'(ch);
    IO_write_data = d;
    q[ch].push_back(d);
    #1;
    chk("wr_stall", 32'(stall), 0);
    step();
    IO_write_en = 0;
  endtask

  task automatic strobe(input int ch, input logic [DATA_W-1:0] d);
    in_strobe[ch] = 1;
    in_data[ch*DATA_W +: DATA_W] = d;
    step();
    in_strobe[ch] = 0;
  endtask

  initial begin
    int pops;
    step();
    step();
    reset_n = 1;
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_stall", 32'(stall), 0);

    // single write to ch4, no fall-through
    IO_write_en = 1; IO_write_sel = 4; IO_write_data = 15'h1234; q[4].push_back(15'h1234);
    #1;
    chk("ch4_valid_same_cycle", 32'(out_valid[4]), 0);
    step();
    IO_write_en = 0;
    chk("ch4_valid", 32'(out_valid[4]), 1);
    chk("ch4_data", 32'(od(4)), 32'h1234);
    IO_read_sel = 4;
    #1;
    chk("ch4_shadow", 32'(IO_read_data), 32'h1234);
    out_ready[4] = 1;
    step();
    out_ready[4] = 0;
    chk("ch4_drained", 32'(out_valid[4]), 0);
    chk("ch4_shadow_kept", 32'(IO_read_data), 32'h1234);

    // fill ch5, fifth write stalls until the head is popped
    for (int k = 0; k < 4; k++) wr(5, 15'h0500 + 15'(k));
    IO_write_en = 1; IO_write_sel = 5; IO_write_data = 15'h0504; q[5].push_back(15'h0504);
    #1;
    chk("ch5_full_stall", 32'(stall), 1);
    step();
    chk("ch5_still_stall", 32'(stall), 1);
    out_ready[5] = 1;
    #1;
    chk("ch5_pop_unstall", 32'(stall), 0);
    step();
    IO_write_en = 0;
    for (int k = 0; k < 10 && out_valid[5]; k++) step();
    out_ready[5] = 0;
    chk("ch5_empty", 32'(out_valid[5]), 0);
    chk("ch5_queue_empty", 32'(q[5].size()), 0);

    // write to an input channel is ignored without stall
    IO_write_en = 1; IO_write_sel = 1; IO_write_data = 15'h7777;
    IO_read_sel = 1;
    #1;
    chk("wr_input_stall", 32'(stall), 0);
    step();
    IO_write_en = 0;
    chk("wr_input_ignored", 32'(IO_read_data), 0);

    // ch6 full, simultaneous push and pop keeps count at depth across the wrap
    for (int k = 0; k < 4; k++) wr(6, 15'h0600 + 15'(k));
    out_ready[6] = 1;
    wr(6, 15'h0604);
    out_ready[6] = 0;
    IO_write_en = 1; IO_write_sel = 6; IO_write_data = 15'h0666;
    #1;
    chk("ch6_count_still_full", 32'(stall), 1);
    IO_write_en = 0;
    out_ready[6] = 1;
    pops = 0;
    for (int k = 0; k < 10 && out_valid[6]; k++) begin
      pops++;
      step();
    end
    out_ready[6] = 0;
    chk("ch6_pop_count", 32'(pops), 4);

    // input ch1 strobe, irq, read clears
    irq_en[1] = 1;
    strobe(1, 15'h0042);
    IO_read_sel = 1;
    #1;
    chk("ch1_data", 32'(IO_read_data), 32'h42);
    step();
    chk("ch1_irq", 32'(irq), 1);
    IO_read_en = 1;
    step();
    IO_read_en = 0;
    step();
    chk("ch1_irq_cleared", 32'(irq), 0);
    chk("ch1_no_overrun", 32'(overrun[1]), 0);

    // ch2 overrun; strobe wins over same-cycle read
    strobe(2, 15'h0011);
    strobe(2, 15'h0022);
    IO_read_sel = 2;
    #1;
    chk("ch2_overrun", 32'(overrun[2]), 1);
    chk("ch2_second_value", 32'(IO_read_data), 32'h22);
    irq_en[2] = 1;
    IO_read_en = 1;
    strobe(2, 15'h0033);
    IO_read_en = 0;
    step();
    chk("ch2_pending_kept", 32'(irq), 1);
    chk("ch2_overrun_sticky", 32'(overrun[2]), 1);

    // reset with traffic in flight
    IO_write_en = 1; IO_write_sel = 7; IO_write_data = 15'h0701;
    step();
    IO_write_data = 15'h0702;
    step();
    IO_write_en = 0;
    strobe(3, 15'h0033);
    chk("pre_rst_ch7_valid", 32'(out_valid[7]), 1);
    reset_n = 0;
    step();
    reset_n = 1;
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_out_data", 32'(out_data[7*DATA_W +: DATA_W]), 0);
    chk("post_rst_overrun", 32'(overrun), 0);
    chk("post_rst_irq", 32'(irq), 0);
    IO_read_sel = 3;
    #1;
    chk("post_rst_in_reg", 32'(IO_read_data), 0);
    IO_read_sel = 7;
    #1;
    chk("post_rst_shadow", 32'(IO_read_data), 0);
    step();
    chk("post_rst_irq_later", 32'(irq), 0);
    for (int c = 0; c < 7; c++) chk($sformatf("final_queue_ch%0d", c), 32'(q[c].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
